// File: rtl/sha256_pkg.sv
// -----------------------------------------------------------------------------
// sha256_pkg
// Shared types and constants for the SHA-256 digest output path.
//   DIGEST_BITS      : digest width (256)
//   WORD_BITS        : streamed word width (32)
//   WORDS_PER_DIGEST : words per digest (8)
//   digest_t / word_t: digest and word containers
//   unload_state_t   : unloader FSM states
//   select_word()    : big-endian word extraction (word 0 = H0)
// -----------------------------------------------------------------------------
package sha256_pkg;

    localparam int DIGEST_BITS      = 256;
    localparam int WORD_BITS        = 32;
    localparam int WORDS_PER_DIGEST = DIGEST_BITS / WORD_BITS;

    typedef logic [DIGEST_BITS-1:0] digest_t;
    typedef logic [WORD_BITS-1:0]   word_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } unload_state_t;

    // Word k sits at bits [255-32k -: 32], i.e. its LSB is at (7-k)*32.
    // With 8 words of 32 bits, (7-k)*32 is simply {~k, 5'b0}, which gives
    // an 8-bit index that exactly spans the 256-bit digest.
    function automatic word_t select_word(input digest_t d, input logic [2:0] idx);
        logic [7:0] lsb;
        lsb = {~idx, 5'b00000};
        return d[lsb +: WORD_BITS];
    endfunction

endpackage

// File: rtl/sha256_digest_unloader_buf.sv
// -----------------------------------------------------------------------------
// digest_buf2
// Two-slot digest FIFO between the SHA-256 core and the word streamer.
//   clk, reset : clock, asynchronous active-high reset (pointers/count only)
//   push, din  : write din into the tail slot
//   pop        : release the head slot
//   dout       : head slot contents (combinational read)
//   count      : occupancy 0..2
//   full/empty : occupancy flags
// A push together with a pop is accepted even when full: the head slot is
// read out during the same cycle it is overwritten, and the new digest
// becomes the tail once the read pointer moves past it.
// -----------------------------------------------------------------------------
module digest_buf2
    import sha256_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  digest_t     din,
    output digest_t     dout,
    output logic [1:0]  count,
    output logic        full,
    output logic        empty
);

    digest_t    slots [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic       do_push;
    logic       do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = slots[rd_ptr];

    // Data storage carries no reset; the read side masks it while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            slots[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sha256_digest_unloader.sv
// -----------------------------------------------------------------------------
// sha256_digest_unloader
// Captures 256-bit digests from the SHA-256 core's one-cycle strobe and
// streams each one as eight big-endian 32-bit words (H0 first).
//   clk, reset : clock, asynchronous active-high reset
//   hash_valid : one-cycle digest strobe; hash_in valid in the same cycle
//   hash_in    : digest, H0 in [255:224], H7 in [31:0]
//   out_valid  : out_data holds a word
//   out_ready  : consumer accepts on out_valid && out_ready
//   out_data   : current word (0 while empty)
//   out_index  : word number 0..7 (0 while empty)
//   out_last   : high while the final word is presented
//   pending    : digests buffered, including the one streaming
//   overflow   : sticky, set when a digest had to be dropped
//   fsm_state  : current unloader state (0 = IDLE, 1 = SEND) for observation
// Handshake: a word transfers on every rising edge where out_valid and
// out_ready are both high; while out_ready is low the presented word,
// index and last flag stay put and out_valid remains high.
// -----------------------------------------------------------------------------
module sha256_digest_unloader
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         hash_valid,
    input  logic [255:0] hash_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_data,
    output logic [2:0]   out_index,
    output logic         out_last,
    output logic [1:0]   pending,
    output logic         overflow,
    output logic         fsm_state
);

    unload_state_t state;
    unload_state_t next_state;
    logic [2:0]    word_cnt;
    logic          handshake;
    logic          push;
    logic          pop;
    logic [1:0]    count;
    logic [1:0]    count_next;
    logic          buf_full;
    logic          buf_empty;
    digest_t       head;

    digest_buf2 u_buf (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (hash_in),
        .dout  (head),
        .count (count),
        .full  (buf_full),
        .empty (buf_empty)
    );

    assign handshake = (state == SEND) && out_ready;
    assign pop       = handshake && (word_cnt == 3'd7);
    // A full buffer can still take a digest when its head is leaving now.
    assign push      = hash_valid && (!buf_full || pop);

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 2'd1;
            2'b01:   count_next = count - 2'd1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (push) begin
                    next_state = SEND;
                end
            end
            SEND: begin
                if (pop && (count_next == 2'd0)) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Wraps 7 -> 0 on the final handshake, so a following digest starts at 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_cnt <= 3'd0;
        end else if (handshake) begin
            word_cnt <= word_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (hash_valid && buf_full && !pop) begin
            overflow <= 1'b1;
        end
    end

    assign out_valid = (state == SEND);
    assign out_data  = out_valid ? select_word(head, word_cnt) : '0;
    assign out_index = out_valid ? word_cnt : 3'd0;
    assign out_last  = out_valid && (word_cnt == 3'd7);
    assign pending   = count;
    assign fsm_state = (state == SEND);

    // The buffer's empty flag is redundant with IDLE; kept for observability.
    logic unused_empty;
    assign unused_empty = buf_empty;

endmodule
